alu_mc: RTL



---
 rtl/alu_mc.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle W-bit ALU with a start/busy/done handshake.
// Single-cycle ops finish one edge after accept; MUL/DIV/MOD iterate W edges
// on operand magnitudes and apply the sign fix-up on the final iteration.
// Result and flags are registered and hold until the next legal completion.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on accept
// EXEC   | single-cycle op, or W-cycle multiply/divide iteration
// DIVZ   | DIV/MOD with B==0, completes in one cycle
module alu_mc #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [4:0]   alu_op,
    input  logic [W-1:0] operandA,
    input  logic [W-1:0] operandB,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] resultAccumulator,
    output logic [3:0]   flags
);
    localparam int LW = $clog2(W);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_MOD = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_XOR = 5'b00111;
    localparam logic [4:0] OP_LSL = 5'b01000;
    localparam logic [4:0] OP_LSR = 5'b01001;
    localparam logic [4:0] OP_ASR = 5'b01010;
    localparam logic [4:0] OP_NOT = 5'b01101;

    localparam logic [W-1:0] MIN_S = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DIVZ = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [2*W-1:0]  mcd_q, mcd_d;
    logic [W-1:0]    mpl_q, mpl_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [W-1:0]    res_q, res_d;
    logic [3:0]      flg_q, flg_d;
    logic            done_q, done_d;

    logic            in_div;
    logic [W-1:0]    abs_a_in;
    logic [W-1:0]    abs_b_in;
    logic            is_iter;

    assign in_div   = (alu_op == OP_DIV) || (alu_op == OP_MOD);
    assign abs_a_in = operandA[W-1] ? -operandA : operandA;
    assign abs_b_in = operandB[W-1] ? -operandB : operandB;
    assign is_iter  = (op_q == OP_MUL) || (op_q == OP_DIV) || (op_q == OP_MOD);

    assign busy              = (state_q != S_IDLE);
    assign done              = done_q;
    assign resultAccumulator = res_q;
    assign flags             = flg_q;

    function automatic logic [3:0] mk_flags(input logic v, input logic c, input logic [W-1:0] r);
        return {v, c, r[W-1], (r == '0)};
    endfunction

    logic [W:0]        sum, dif, shl, shr;
    logic signed [W:0] sar;
    logic [LW-1:0]     sh_amt;
    logic [W-1:0]      s_res;
    logic              s_c, s_v, s_legal;

    // Single-cycle datapath: add/sub/logic/shift result and carry/overflow.
    always_comb begin
        sh_amt  = b_q[LW-1:0];
        sum     = {1'b0, a_q} + {1'b0, b_q};
        dif     = {1'b0, a_q} - {1'b0, b_q};
        shl     = {1'b0, a_q} << sh_amt;
        shr     = {a_q, 1'b0} >> sh_amt;
        sar     = $signed({a_q, 1'b0}) >>> sh_amt;
        s_res   = '0;
        s_c     = 1'b0;
        s_v     = 1'b0;
        s_legal = 1'b1;
        case (op_q)
            OP_ADD: begin
                s_res = sum[W-1:0];
                s_c   = sum[W];
                s_v   = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
            end
            OP_SUB: begin
                s_res = dif[W-1:0];
                s_c   = dif[W];
                s_v   = (a_q[W-1] != b_q[W-1]) && (dif[W-1] != a_q[W-1]);
            end
            OP_AND: s_res = a_q & b_q;
            OP_OR:  s_res = a_q | b_q;
            OP_XOR: s_res = a_q ^ b_q;
            OP_NOT: s_res = ~a_q;
            // The extra bit beside the operand catches the last bit shifted out,
            // which is naturally zero for a zero shift amount.
            OP_LSL: begin
                s_res = shl[W-1:0];
                s_c   = shl[W];
            end
            OP_LSR: begin
                s_res = shr[W:1];
                s_c   = shr[0];
            end
            OP_ASR: begin
                s_res = sar[W:1];
                s_c   = sar[0];
            end
            default: s_legal = 1'b0;
        endcase
    end

    logic [2*W-1:0] acc_nx, prod;
    logic [W:0]     rem_sh;
    logic [W-1:0]   rem_sub, rem_nx, quo_nx, quot, remd;
    logic           neg_res;
    logic [W-1:0]   it_res;
    logic           it_v;

    // One shift-add / restoring-divide step plus final sign fix-up.
    always_comb begin
        acc_nx  = mpl_q[0] ? (acc_q + mcd_q) : acc_q;
        rem_sh  = {rem_q, quo_q[W-1]};
        rem_sub = rem_sh[W-1:0] - dvs_q;
        if (rem_sh >= {1'b0, dvs_q}) begin
            rem_nx = rem_sub;
            quo_nx = {quo_q[W-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[W-1:0];
            quo_nx = {quo_q[W-2:0], 1'b0};
        end
        neg_res = a_q[W-1] ^ b_q[W-1];
        prod    = neg_res ? -acc_nx : acc_nx;
        quot    = neg_res ? -quo_nx : quo_nx;
        remd    = a_q[W-1] ? -rem_nx : rem_nx;
        it_res  = '0;
        it_v    = 1'b0;
        case (op_q)
            OP_MUL: begin
                it_res = prod[W-1:0];
                it_v   = !((&prod[2*W-1:W-1]) || !(|prod[2*W-1:W-1]));
            end
            // MIN / -1 wraps back to MIN; only the overflow flag tells it apart.
            OP_DIV: begin
                it_res = quot;
                it_v   = (a_q == MIN_S) && (&b_q);
            end
            default: it_res = remd;
        endcase
    end

    // Next-state and register updates for the handshake FSM.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcd_d   = mcd_q;
        mpl_d   = mpl_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        flg_d   = flg_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = alu_op;
                    a_d     = operandA;
                    b_d     = operandB;
                    cnt_d   = LW'(W - 1);
                    acc_d   = '0;
                    mcd_d   = {{W{1'b0}}, abs_a_in};
                    mpl_d   = abs_b_in;
                    rem_d   = '0;
                    quo_d   = abs_a_in;
                    dvs_d   = abs_b_in;
                    state_d = (in_div && (operandB == '0)) ? S_DIVZ : S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_iter) begin
                    acc_d = acc_nx;
                    mcd_d = mcd_q << 1;
                    mpl_d = mpl_q >> 1;
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    if (cnt_q == '0) begin
                        res_d   = it_res;
                        flg_d   = mk_flags(it_v, 1'b0, it_res);
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else begin
                    if (s_legal) begin
                        res_d = s_res;
                        flg_d = mk_flags(s_v, s_c, s_res);
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DIVZ: begin
                res_d   = (op_q == OP_DIV) ? {W{1'b1}} : a_q;
                flg_d   = mk_flags(1'b1, 1'b0, (op_q == OP_DIV) ? {W{1'b1}} : a_q);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcd_q   <= '0;
            mpl_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcd_q   <= mcd_d;
            mpl_q   <= mpl_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            done_q  <= done_d;
        end
    end

endmodule
